// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues pc_i to instruction memory, tracks in-order
// responses in a DEPTH-entry queue and hands {inst, pc} pairs to decode.
module if_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        start_i_n,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic        fetch_stall_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        id_ready_i
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [DEPTH-1:0] dvalid_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q, kill_q;

  logic [CW-1:0]    pending_cnt;
  logic             fill_found;
  logic [PW-1:0]    fill_idx;
  logic [PW-1:0]    scan_idx;
  logic [CW-1:0]    kill_d;
  logic             grant, pop, fill_live;

  // Locate the oldest unfilled entry and count unfilled entries in the live window.
  always_comb begin
    pending_cnt = '0;
    fill_found  = 1'b0;
    fill_idx    = '0;
    scan_idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && !dvalid_q[scan_idx]) begin
        pending_cnt = pending_cnt + CW'(1);
        if (!fill_found) begin
          fill_found = 1'b1;
          fill_idx   = scan_idx;
        end
      end
    end
  end

  always_comb begin
    imem_req_o    = start_i_n & ~flush_i &
                    (({1'b0, count_q} + {1'b0, kill_q}) < DEPTH_W);
    imem_addr_o   = pc_i;
    grant         = imem_req_o & imem_gnt_i;
    fetch_stall_o = ~grant;
    inst_valid_o  = (count_q != '0) & dvalid_q[head_q] & ~flush_i;
    inst_o        = inst_valid_o ? data_mem[head_q] : NOP;
    inst_pc_o     = pc_mem[head_q];
    pop           = inst_valid_o & id_ready_i;
    fill_live     = imem_rvalid_i & ~flush_i & (kill_q == '0) & fill_found;
  end

  // Flush turns every unfilled entry into a response still owed by memory.
  always_comb begin
    kill_d = kill_q;
    if (flush_i) begin
      kill_d = kill_q + pending_cnt - CW'((imem_rvalid_i && (kill_q == '0)) ? 1 : 0);
    end else if (imem_rvalid_i && (kill_q != '0)) begin
      kill_d = kill_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge start_i_n) begin
    if (!start_i_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      kill_q   <= '0;
      dvalid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      kill_q <= kill_d;
      if (flush_i) begin
        head_q  <= tail_q;
        count_q <= '0;
      end else begin
        if (grant) begin
          pc_mem[tail_q]   <= pc_i;
          dvalid_q[tail_q] <= 1'b0;
          tail_q           <= tail_q + PW'(1);
        end
        if (fill_live) begin
          data_mem[fill_idx] <= imem_rdata_i;
          dvalid_q[fill_idx] <= 1'b1;
        end
        if (pop) begin
          head_q <= head_q + PW'(1);
        end
        if (grant && !pop) begin
          count_q <= count_q + CW'(1);
        end else if (!grant && pop) begin
          count_q <= count_q - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: table-driven stream, directed flush/reset corners,
// and randomized traffic against a queue-based reference model.
module tb_if_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] XMASK = 32'hA5A5_0000;

  logic        clk_i = 1'b0;
  logic        start_i_n;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        fetch_stall_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        id_ready_i;

  if_fetch_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk_i(clk_i), .start_i_n(start_i_n), .pc_i(pc_i), .flush_i(flush_i),
    .fetch_stall_o(fetch_stall_o), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .id_ready_i(id_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] pc; logic [31:0] data; logic dv; } ent_t;
  typedef struct { int due; logic [31:0] data; } mresp_t;
  typedef struct { logic gnt; logic rdy; logic e_req; logic e_stall; logic e_valid; logic [31:0] e_pc; } tv_t;

  ent_t   mdl[$];
  mresp_t mq[$];
  int     kill, cyc, last_due, lat_lo, lat_hi;
  logic [31:0] pc;
  int     n_checks, n_fail;
  logic        obs_valid, obs_req, obs_stall;
  logic [31:0] obs_pc, obs_inst, obs_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic hold_reset();
    start_i_n = 1'b0;
    flush_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    id_ready_i = 1'b0; pc_i = '0; imem_rdata_i = '0;
    mdl.delete(); mq.delete(); kill = 0; pc = '0; last_due = -1;
    #1;
    chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("rst_inst",  inst_o, NOP);
    chk("rst_pc",    inst_pc_o, 32'd0);
    chk("rst_req",   {31'b0, imem_req_o}, 32'd0);
    chk("rst_stall", {31'b0, fetch_stall_o}, 32'd1);
    @(posedge clk_i); @(posedge clk_i); #1;
    start_i_n = 1'b1;
  endtask

  // One clock: drive inputs, check outputs at negedge, advance model, memory and PC.
  task automatic run_cycle(input logic fl, input logic g, input logic rdy, input logic [31:0] redir);
    logic rv, e_req, e_valid, e_stall, pop;
    logic [31:0] e_inst;
    int fi, pend, lat, due;
    rv = (mq.size() > 0) && (mq[0].due <= cyc);
    pc_i = pc; flush_i = fl; imem_gnt_i = g; id_ready_i = rdy;
    imem_rvalid_i = rv; imem_rdata_i = rv ? mq[0].data : $urandom;
    e_req   = !fl && ((mdl.size() + kill) < DEPTH);
    e_valid = (mdl.size() > 0) && mdl[0].dv && !fl;
    e_inst  = e_valid ? mdl[0].data : NOP;
    e_stall = !(e_req && g);
    @(negedge clk_i);
    obs_valid = inst_valid_o; obs_pc = inst_pc_o; obs_inst = inst_o;
    obs_req = imem_req_o; obs_stall = fetch_stall_o; obs_addr = imem_addr_o;
    chk("imem_req",   {31'b0, imem_req_o}, {31'b0, e_req});
    chk("imem_addr",  imem_addr_o, pc);
    chk("fetch_stall", {31'b0, fetch_stall_o}, {31'b0, e_stall});
    chk("inst_valid", {31'b0, inst_valid_o}, {31'b0, e_valid});
    chk("inst",       inst_o, e_inst);
    if (e_valid) chk("inst_pc", inst_pc_o, mdl[0].pc);
    if (fl) begin
      pend = 0;
      foreach (mdl[k]) if (!mdl[k].dv) pend++;
      kill = kill + pend - ((rv && kill == 0) ? 1 : 0);
      mdl.delete();
    end else begin
      pop = e_valid && rdy;
      if (rv) begin
        if (kill > 0) kill--;
        else begin
          fi = -1;
          foreach (mdl[k]) if (!mdl[k].dv && fi < 0) fi = k;
          n_checks++;
          if (fi < 0) begin
            n_fail++;
            $display("FAIL fill_target at cycle %0d: response with no pending entry, queue size %0d", cyc, mdl.size());
          end else begin
            mdl[fi].data = mq[0].data;
            mdl[fi].dv   = 1'b1;
          end
        end
      end
      if (pop) void'(mdl.pop_front());
      if (e_req && g) mdl.push_back('{pc, 32'h0, 1'b0});
    end
    if (rv) void'(mq.pop_front());
    if (e_req && g) begin
      lat = $urandom_range(lat_hi, lat_lo);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{due, pc ^ XMASK});
    end
    pc = fl ? redir : ((e_req && g) ? pc + 32'd4 : pc);
    @(posedge clk_i); #1;
    cyc++;
  endtask

  tv_t tv[19];
  bit  seen;

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; lat_lo = 1; lat_hi = 1;
    //        gnt rdy req stl vld pc
    tv[0]  = '{1, 1, 1, 0, 0, 32'd0};
    tv[1]  = '{1, 1, 1, 0, 0, 32'd0};
    tv[2]  = '{1, 1, 1, 0, 1, 32'd0};
    tv[3]  = '{1, 1, 1, 0, 1, 32'd4};
    tv[4]  = '{1, 0, 1, 0, 1, 32'd8};
    tv[5]  = '{1, 0, 1, 0, 1, 32'd8};
    tv[6]  = '{1, 0, 0, 1, 1, 32'd8};
    tv[7]  = '{1, 0, 0, 1, 1, 32'd8};
    tv[8]  = '{1, 0, 0, 1, 1, 32'd8};
    tv[9]  = '{1, 0, 0, 1, 1, 32'd8};
    tv[10] = '{1, 1, 0, 1, 1, 32'd8};
    tv[11] = '{1, 1, 1, 0, 1, 32'd12};
    tv[12] = '{1, 1, 1, 0, 1, 32'd16};
    tv[13] = '{0, 1, 1, 1, 1, 32'd20};
    tv[14] = '{0, 1, 1, 1, 1, 32'd24};
    tv[15] = '{0, 1, 1, 1, 1, 32'd28};
    tv[16] = '{1, 1, 1, 0, 0, 32'd0};
    tv[17] = '{1, 1, 1, 0, 0, 32'd0};
    tv[18] = '{1, 1, 1, 0, 1, 32'd32};

    // Stream, backpressure and withheld grant with a 1-cycle memory.
    hold_reset();
    for (int i = 0; i < 19; i++) begin
      run_cycle(1'b0, tv[i].gnt, tv[i].rdy, 32'h0);
      chk("tv_req",   {31'b0, obs_req},   {31'b0, tv[i].e_req});
      chk("tv_stall", {31'b0, obs_stall}, {31'b0, tv[i].e_stall});
      chk("tv_valid", {31'b0, obs_valid}, {31'b0, tv[i].e_valid});
      if (tv[i].e_valid) begin
        chk("tv_pc",   obs_pc,   tv[i].e_pc);
        chk("tv_inst", obs_inst, tv[i].e_pc ^ XMASK);
      end
    end

    // Flush with two requests outstanding behind a 3-cycle memory.
    hold_reset();
    lat_lo = 3; lat_hi = 3; pc = 32'h18;
    run_cycle(1'b0, 1'b1, 1'b1, 32'h0);
    run_cycle(1'b0, 1'b1, 1'b1, 32'h0);
    run_cycle(1'b1, 1'b1, 1'b1, 32'h100);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      run_cycle(1'b0, 1'b1, 1'b1, 32'h0);
      if (obs_valid) begin
        seen = 1'b1;
        chk("flush2_first_pc", obs_pc, 32'h100);
      end
    end
    chk("flush2_seen", {31'b0, seen}, 32'd1);

    // Flush in the same cycle as a fill, one more entry pending.
    hold_reset();
    lat_lo = 2; lat_hi = 2; pc = 32'h40;
    run_cycle(1'b0, 1'b1, 1'b1, 32'h0);
    run_cycle(1'b0, 1'b1, 1'b1, 32'h0);
    run_cycle(1'b1, 1'b1, 1'b1, 32'h200);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      run_cycle(1'b0, 1'b1, 1'b1, 32'h0);
      if (obs_valid) begin
        seen = 1'b1;
        chk("no_stale", {31'b0, obs_pc < 32'h200}, 32'd0);
      end
    end
    chk("flushfill_seen", {31'b0, seen}, 32'd1);

    // Asynchronous reset between edges with three entries queued.
    hold_reset();
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 10 && mdl.size() != 3; i++) run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    #2;
    start_i_n = 1'b0;
    #1;
    chk("async_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("async_inst",  inst_o, NOP);
    hold_reset();
    run_cycle(1'b0, 1'b1, 1'b1, 32'h0);
    chk("restart_addr", obs_addr, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      run_cycle(1'b0, 1'b1, 1'b1, 32'h0);
      if (obs_valid) begin
        seen = 1'b1;
        chk("restart_first_pc", obs_pc, 32'h0);
      end
    end
    chk("restart_seen", {31'b0, seen}, 32'd1);

    // Randomized traffic; flushes only in cycles without a response.
    hold_reset();
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 600; i++) begin
      logic fl;
      fl = ($urandom_range(99, 0) < 4) && !((mq.size() > 0) && (mq[0].due <= cyc));
      run_cycle(fl, $urandom_range(99, 0) < 75, $urandom_range(99, 0) < 70,
                $urandom & 32'h0000_FFFC);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
